vacc_ctrl: RTL

Integration sequencer for the FFT-channel vector accumulator. It aligns to an upstream sync, tracks channel and frame position, and pulses new_acc before the first sample of every integration of acc_len frames. It also gates the accumulator's dump stream so that the stale first dump after arming is discarded, marks the last channel of each dump, and counts completed integrations. It sits between the register interface / sync generator and the accumulator.

---
 rtl/vacc_ctrl_pkg.sv | 23 ++
 rtl/vacc_dump_gate.sv | 58 +++++
 rtl/vacc_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vacc_ctrl_pkg.sv
// Shared types and helpers for the vector-accumulator integration sequencer.
// Holds the sequencer state encoding, the channel-index width helper and the acc_len clamp.
package vacc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // acc_len is widened to this many bits before clamping.
  localparam int ACC_LEN_MAX_W = 64;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A frame count of zero makes no sense for an integration, so it is treated as one.
  function automatic logic [ACC_LEN_MAX_W-1:0] clamp_acc_len(input logic [ACC_LEN_MAX_W-1:0] len);
    return (len == '0) ? ACC_LEN_MAX_W'(1) : len;
  endfunction

endpackage

// File: rtl/vacc_dump_gate.sv
// Dump-side gating for the vector accumulator: counts dump channels, discards the stale
// first dump after arming or realignment, flags the last channel and counts good dumps.
module vacc_dump_gate
  import vacc_ctrl_pkg::*;
#(
  parameter int VECTOR_LEN   = 64,
  parameter int ACC_ID_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    realign,
  input  logic                    acc_dout_valid,
  output logic                    dout_valid_gated,
  output logic                    dout_last,
  output logic [ACC_ID_WIDTH-1:0] acc_id
);

  localparam int                CHAN_W    = chan_w(VECTOR_LEN);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(VECTOR_LEN - 1);
  localparam logic [CHAN_W-1:0] CHAN_ONE  = CHAN_W'(1);

  logic [CHAN_W-1:0]       dump_chan_q;
  logic                    discard_q;
  logic [ACC_ID_WIDTH-1:0] acc_id_q;
  logic                    dump_wrap;

  assign dump_wrap        = acc_dout_valid && (dump_chan_q == CHAN_LAST);
  assign dout_valid_gated = acc_dout_valid & ~discard_q;
  assign dout_last        = dout_valid_gated & (dump_chan_q == CHAN_LAST);
  assign acc_id           = acc_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_chan_q <= '0;
      discard_q   <= 1'b1;
      acc_id_q    <= '0;
    end else if (clear) begin
      dump_chan_q <= '0;
      discard_q   <= 1'b1;
      acc_id_q    <= '0;
    end else begin
      if (acc_dout_valid) begin
        dump_chan_q <= dump_wrap ? '0 : dump_chan_q + CHAN_ONE;
      end
      if (dump_wrap && !discard_q) begin
        acc_id_q <= acc_id_q + ACC_ID_WIDTH'(1);
      end
      // A realignment makes whatever the accumulator dumps next stale again.
      if (realign) begin
        discard_q <= 1'b1;
      end else if (dump_wrap) begin
        discard_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vacc_ctrl.sv
// Integration sequencer for the FFT-channel vector accumulator: sync alignment, channel and
// frame tracking, new_acc generation and dump gating. Optional macro: VACC_CTRL_SYNC_CHECK_EN.
module vacc_ctrl
  import vacc_ctrl_pkg::*;
#(
  parameter int VECTOR_LEN    = 64,
  parameter int ACC_LEN_WIDTH = 32,
  parameter int ACC_ID_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arm,
  input  logic [ACC_LEN_WIDTH-1:0]       acc_len,
  input  logic                           sync_in,
  input  logic                           din_valid,
  input  logic                           acc_dout_valid,
  output logic                           new_acc,
  output logic                           dout_valid_gated,
  output logic                           dout_last,
  output logic [ACC_ID_WIDTH-1:0]        acc_id,
  output logic [chan_w(VECTOR_LEN)-1:0]  chan_idx,
  output logic [ACC_LEN_WIDTH-1:0]       frame_idx,
  output logic                           busy,
  output logic                           sync_err,
  output logic [1:0]                     state_dbg
);

  // din_valid and acc_dout_valid are single-cycle strobes with no backpressure: every cycle
  // they are high carries one sample; this block never stalls either stream.

  localparam int                       CHAN_W    = chan_w(VECTOR_LEN);
  localparam logic [CHAN_W-1:0]        CHAN_LAST = CHAN_W'(VECTOR_LEN - 1);
  localparam logic [CHAN_W-1:0]        CHAN_ONE  = CHAN_W'(1);
  localparam logic [ACC_LEN_WIDTH-1:0] LEN_ONE   = ACC_LEN_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [CHAN_W-1:0]        chan_q, chan_d;
  logic [ACC_LEN_WIDTH-1:0] frame_q, frame_d;
  logic [ACC_LEN_WIDTH-1:0] acc_len_q, acc_len_d;
  logic [ACC_LEN_WIDTH-1:0] len_clamped;
  logic                     new_acc_q, new_acc_d;
  logic                     resync;
  logic                     realign;

  assign len_clamped = ACC_LEN_WIDTH'(clamp_acc_len(ACC_LEN_MAX_W'(acc_len)));

`ifdef VACC_CTRL_SYNC_CHECK_EN
  logic sync_err_q;

  // A sync landing mid-frame means upstream slipped; realign to it and remember the slip.
  assign resync = sync_in && (chan_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err_q <= 1'b0;
    end else if (arm) begin
      sync_err_q <= 1'b0;
    end else if ((state_q == ST_RUN) && resync) begin
      sync_err_q <= 1'b1;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign resync   = 1'b0;
  assign sync_err = 1'b0;
`endif

  assign realign = !arm && (state_q == ST_RUN) && resync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      chan_q    <= '0;
      frame_q   <= '0;
      acc_len_q <= LEN_ONE;
      new_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      frame_q   <= frame_d;
      acc_len_q <= acc_len_d;
      new_acc_q <= new_acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    frame_d   = frame_q;
    acc_len_d = acc_len_q;
    new_acc_d = 1'b0;

    if (arm) begin
      state_d   = ST_WAIT_SYNC;
      chan_d    = '0;
      frame_d   = '0;
      acc_len_d = len_clamped;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT_SYNC: begin
          // The sample coincident with sync precedes channel 0 and is not counted.
          if (sync_in) begin
            state_d   = ST_RUN;
            chan_d    = '0;
            frame_d   = '0;
            new_acc_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (resync) begin
            chan_d    = '0;
            frame_d   = '0;
            new_acc_d = 1'b1;
          end else if (din_valid) begin
            if (chan_q == CHAN_LAST) begin
              chan_d = '0;
              // Integration boundary: acc_len is only re-sampled here.
              if (frame_q == acc_len_q - LEN_ONE) begin
                frame_d   = '0;
                new_acc_d = 1'b1;
                acc_len_d = len_clamped;
              end else begin
                frame_d = frame_q + LEN_ONE;
              end
            end else begin
              chan_d = chan_q + CHAN_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  vacc_dump_gate #(
    .VECTOR_LEN   (VECTOR_LEN),
    .ACC_ID_WIDTH (ACC_ID_WIDTH)
  ) u_dump_gate (
    .clk              (clk),
    .rst              (rst),
    .clear            (arm),
    .realign          (realign),
    .acc_dout_valid   (acc_dout_valid),
    .dout_valid_gated (dout_valid_gated),
    .dout_last        (dout_last),
    .acc_id           (acc_id)
  );

  assign new_acc   = new_acc_q;
  assign chan_idx  = chan_q;
  assign frame_idx = frame_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule
